hazard_unit: RTL and testbench

Parametrised hazard controller for the pipelined successor of the single-cycle RV32I core (F/D/E/M/W stages).
- Generates ALU operand forwarding selects, load-use and RAW stalls, and control-hazard flushes.
- Runs a multi-cycle data-memory wait FSM that freezes the pipeline for a configurable memory latency.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the stage registers in the core top; all stage registers consume its stall/flush outputs.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/mem_wait_fsm.sv | 53 +++++
 rtl/hazard_unit.sv | 126 ++++++++++++
 tb/tb_hazard_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// memory-wait FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE
    } mem_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Freezes the pipeline for MEM_LATENCY cycles per data-memory access, then
// spends one RELEASE cycle letting the finished access leave M.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_LATENCY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic MemAccessM,
    output logic memStall
);

    localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    mem_state_t     state;
    logic [CW-1:0]  count;
    logic           start;

    assign start = (MEM_LATENCY > 0) && MemAccessM;

    // The first stall cycle is the IDLE cycle that sees the access, so the
    // stall has to be decoded combinationally from the current state.
    always_comb begin
        memStall = !rst && ((state == WAIT) || ((state == IDLE) && start));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= CW'(1);
                        state <= (MEM_LATENCY == 1) ? RELEASE : WAIT;
                    end
                end
                WAIT: begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RV32I pipeline: operand forwarding,
// load-use/RAW stalls, branch flushes, memory-wait freeze and a stall counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_LATENCY    = 0,
    parameter int FWD_ENABLE     = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] rdE,
    input  logic [REG_ADDR_WIDTH-1:0] rdM,
    input  logic [REG_ADDR_WIDTH-1:0] rdW,
    input  logic                      RegWriteE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      ResultSrcE,
    input  logic                      MemAccessM,
    input  logic                      PCSrcE,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    logic     mem_stall;
    logic     lw_stall;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic we,
                                     input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    function automatic fwd_sel_t pick_fwd(input logic [REG_ADDR_WIDTH-1:0] rs,
                                          input logic we_m,
                                          input logic [REG_ADDR_WIDTH-1:0] rd_m,
                                          input logic we_w,
                                          input logic [REG_ADDR_WIDTH-1:0] rd_w);
        if (FWD_ENABLE == 0)              return FWD_RF;
        if (reg_hit(we_m, rd_m, rs))      return FWD_MEM;
        if (reg_hit(we_w, rd_w, rs))      return FWD_WB;
        return FWD_RF;
    endfunction

    mem_wait_fsm #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_mem_wait (
        .clk       (clk),
        .rst       (rst),
        .MemAccessM(MemAccessM),
        .memStall  (mem_stall)
    );

    // Without forwarding every in-flight writer of a D source must drain first.
    always_comb begin
        fwd_a = pick_fwd(rs1E, RegWriteM, rdM, RegWriteW, rdW);
        fwd_b = pick_fwd(rs2E, RegWriteM, rdM, RegWriteW, rdW);
        if (FWD_ENABLE != 0) begin
            lw_stall = ResultSrcE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
        end else begin
            lw_stall = reg_hit(RegWriteE, rdE, rs1D) || reg_hit(RegWriteE, rdE, rs2D) ||
                       reg_hit(RegWriteM, rdM, rs1D) || reg_hit(RegWriteM, rdM, rs2D) ||
                       reg_hit(RegWriteW, rdW, rs1D) || reg_hit(RegWriteW, rdW, rs2D);
        end
    end

    // Priority: reset, memory freeze, taken branch, then data hazard.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((StallF || StallD || StallE || StallM) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Checks several hazard_unit configurations side by side against a
// behavioural model: directed scenarios first, then random traffic.
module tb_hazard_unit;

    localparam int N = 5;

    function automatic int cfgFwd(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int cfgLat(input int k);
        case (k)
            2:       return 3;
            3:       return 2;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfgCw(input int k);
        return (k == 4) ? 3 : 32;
    endfunction

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1D;
        logic [4:0] rs2D;
        logic [4:0] rs1E;
        logic [4:0] rs2E;
        logic [4:0] rdE;
        logic [4:0] rdM;
        logic [4:0] rdW;
        logic       RegWriteE;
        logic       RegWriteM;
        logic       RegWriteW;
        logic       ResultSrcE;
        logic       MemAccessM;
        logic       PCSrcE;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MemAccessM, PCSrcE;

    logic [N-1:0][1:0]  fa, fb;
    logic [N-1:0]       sf, sd, se, sm, fd, fe, fw;
    logic [N-1:0][31:0] cnt;

    int    errors = 0;
    int    checks = 0;
    int    memLeft    [N];
    bit    memRelease [N];
    longint expCnt    [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int CW = cfgCw(k);
        logic [CW-1:0] cntLocal;
        hazard_unit #(
            .REG_ADDR_WIDTH(5),
            .MEM_LATENCY   (cfgLat(k)),
            .FWD_ENABLE    (cfgFwd(k)),
            .CNT_WIDTH     (CW)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .rs1D        (rs1D),
            .rs2D        (rs2D),
            .rs1E        (rs1E),
            .rs2E        (rs2E),
            .rdE         (rdE),
            .rdM         (rdM),
            .rdW         (rdW),
            .RegWriteE   (RegWriteE),
            .RegWriteM   (RegWriteM),
            .RegWriteW   (RegWriteW),
            .ResultSrcE  (ResultSrcE),
            .MemAccessM  (MemAccessM),
            .PCSrcE      (PCSrcE),
            .ForwardAE   (fa[k]),
            .ForwardBE   (fb[k]),
            .StallF      (sf[k]),
            .StallD      (sd[k]),
            .StallE      (se[k]),
            .StallM      (sm[k]),
            .FlushD      (fd[k]),
            .FlushE      (fe[k]),
            .FlushW      (fw[k]),
            .stall_cycles(cntLocal)
        );
        assign cnt[k] = 32'(cntLocal);
    end

    function automatic bit hits(input bit we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    task automatic checkValue(input string tag, input int k,
                              input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        rst        = s.rst;
        rs1D       = s.rs1D;
        rs2D       = s.rs2D;
        rs1E       = s.rs1E;
        rs2E       = s.rs2E;
        rdE        = s.rdE;
        rdM        = s.rdM;
        rdW        = s.rdW;
        RegWriteE  = s.RegWriteE;
        RegWriteM  = s.RegWriteM;
        RegWriteW  = s.RegWriteW;
        ResultSrcE = s.ResultSrcE;
        MemAccessM = s.MemAccessM;
        PCSrcE     = s.PCSrcE;
        #1;
    endtask

    // Compare every instance with the model, then advance the model across
    // the coming clock edge and move to the next falling edge.
    task automatic checkOutput();
        for (int k = 0; k < N; k++) begin
            bit        fwdOn, memExp, lw, anyStall;
            logic [1:0] expA, expB;
            logic [6:0] expCtl;
            longint     maxCnt;
            fwdOn = (cfgFwd(k) != 0);
            if (rst)                memExp = 0;
            else if (memRelease[k]) memExp = 0;
            else if (memLeft[k] > 0) memExp = 1;
            else                    memExp = MemAccessM && (cfgLat(k) > 0);

            if (fwdOn)
                lw = ResultSrcE && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
            else
                lw = hits(RegWriteE, rdE, rs1D) || hits(RegWriteE, rdE, rs2D) ||
                     hits(RegWriteM, rdM, rs1D) || hits(RegWriteM, rdM, rs2D) ||
                     hits(RegWriteW, rdW, rs1D) || hits(RegWriteW, rdW, rs2D);

            expA = 2'b00;
            expB = 2'b00;
            if (!rst && fwdOn) begin
                expA = hits(RegWriteM, rdM, rs1E) ? 2'b10 : (hits(RegWriteW, rdW, rs1E) ? 2'b01 : 2'b00);
                expB = hits(RegWriteM, rdM, rs2E) ? 2'b10 : (hits(RegWriteW, rdW, rs2E) ? 2'b01 : 2'b00);
            end

            // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
            if (rst)         expCtl = 7'b0000_111;
            else if (memExp) expCtl = 7'b1111_001;
            else if (PCSrcE) expCtl = 7'b0000_110;
            else if (lw)     expCtl = 7'b1100_010;
            else             expCtl = 7'b0000_000;

            checkValue("ForwardAE", k, 32'(fa[k]), 32'(expA));
            checkValue("ForwardBE", k, 32'(fb[k]), 32'(expB));
            checkValue("stall_flush", k, 32'({sf[k], sd[k], se[k], sm[k], fd[k], fe[k], fw[k]}), 32'(expCtl));
            checkValue("stall_cycles", k, cnt[k], 32'(expCnt[k]));

            anyStall = (expCtl[6:3] != 4'b0000);
            maxCnt   = (longint'(1) << cfgCw(k)) - 1;
            if (rst) begin
                memLeft[k]    = 0;
                memRelease[k] = 0;
                expCnt[k]     = 0;
            end else begin
                if (anyStall && expCnt[k] < maxCnt) expCnt[k]++;
                if (memRelease[k]) begin
                    memRelease[k] = 0;
                end else if (memLeft[k] > 0) begin
                    memLeft[k]--;
                    if (memLeft[k] == 0) memRelease[k] = 1;
                end else if (MemAccessM && cfgLat(k) > 0) begin
                    memLeft[k] = cfgLat(k) - 1;
                    if (memLeft[k] == 0) memRelease[k] = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        stim_t s;
        logic [4:0] memPat;
        logic [2:0] brPat;

        for (int k = 0; k < N; k++) begin
            memLeft[k] = 0; memRelease[k] = 0; expCnt[k] = 0;
        end
        s = '0; s.rst = 1'b1;
        applyStimulus(s);
        @(posedge clk);
        @(negedge clk);
        $display("[TB] reset released, directed scenarios start");

        s = '0; s.rst = 1'b1;
        applyStimulus(s);
        checkValue("reset_flushW", 0, 32'(fw[0]), 32'd1);
        checkOutput();

        // M wins over W; with rdM=x0 the W result is forwarded
        s = '0; s.RegWriteM = 1; s.rdM = 5; s.rs1E = 5; s.RegWriteW = 1; s.rdW = 5;
        applyStimulus(s);
        checkValue("plan1_fwd_mem", 0, 32'(fa[0]), 32'd2);
        checkValue("plan1_nofwd", 1, 32'(fa[1]), 32'd0);
        checkOutput();
        s.rdM = 0;
        applyStimulus(s);
        checkValue("plan1_fwd_wb", 0, 32'(fa[0]), 32'd1);
        checkOutput();

        // Load-use, then branch overriding it
        s = '0; s.ResultSrcE = 1; s.rdE = 7; s.rs2D = 7;
        applyStimulus(s);
        checkValue("plan2_lw_stallF", 0, 32'(sf[0]), 32'd1);
        checkValue("plan2_lw_flushE", 0, 32'(fe[0]), 32'd1);
        checkOutput();
        s.PCSrcE = 1;
        applyStimulus(s);
        checkValue("plan2_br_stallF", 0, 32'(sf[0]), 32'd0);
        checkValue("plan2_br_flushD", 0, 32'(fd[0]), 32'd1);
        checkOutput();

        // No-forwarding RAW stall on a W writer; x0 never stalls
        s = '0; s.RegWriteW = 1; s.rdW = 3; s.rs1D = 3;
        applyStimulus(s);
        checkValue("plan3_raw_stall", 1, 32'(sf[1]), 32'd1);
        checkValue("plan3_fwd_nostall", 0, 32'(sf[0]), 32'd0);
        checkOutput();
        s.rs1D = 0; s.rdW = 0;
        applyStimulus(s);
        checkValue("plan3_x0", 1, 32'(sf[1]), 32'd0);
        checkOutput();

        // Held access with latency 3: stall, stall, stall, release, stall
        s = '0; s.rst = 1; applyStimulus(s); checkOutput();
        memPat = 5'b10111;
        s = '0; s.MemAccessM = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s);
            checkValue("plan4_stallM", i, 32'(sm[2]), 32'(memPat[i]));
            checkValue("plan4_lat0", i, 32'(sm[0]), 32'd0);
            if (i == 3) checkValue("plan4_count", i, cnt[2], 32'd3);
            checkOutput();
        end

        // Branch during a latency-2 wait is deferred to the release cycle
        s = '0; s.rst = 1; applyStimulus(s); checkOutput();
        brPat = 3'b100;
        s = '0; s.MemAccessM = 1; s.PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkValue("plan5_flushD", i, 32'(fd[3]), 32'(brPat[i]));
            checkOutput();
        end

        // Reset in the middle of a wait
        s = '0; s.rst = 1; applyStimulus(s); checkOutput();
        s = '0; s.MemAccessM = 1; applyStimulus(s); checkOutput();
        s.rst = 1; applyStimulus(s); checkOutput();
        s = '0; applyStimulus(s);
        checkValue("plan6_stallM", 2, 32'(sm[2]), 32'd0);
        checkValue("plan6_count", 2, cnt[2], 32'd0);
        checkOutput();

        $display("[TB] random traffic start");
        for (int i = 0; i < 400; i++) begin
            s            = '0;
            s.rst        = ($urandom_range(0, 39) == 0);
            s.rs1D       = 5'($urandom_range(0, 3));
            s.rs2D       = 5'($urandom_range(0, 3));
            s.rs1E       = 5'($urandom_range(0, 3));
            s.rs2E       = 5'($urandom_range(0, 3));
            s.rdE        = 5'($urandom_range(0, 3));
            s.rdM        = 5'($urandom_range(0, 3));
            s.rdW        = 5'($urandom_range(0, 3));
            s.RegWriteE  = 1'($urandom_range(0, 1));
            s.RegWriteM  = 1'($urandom_range(0, 1));
            s.RegWriteW  = 1'($urandom_range(0, 1));
            s.ResultSrcE = 1'($urandom_range(0, 1));
            s.MemAccessM = ($urandom_range(0, 2) == 0);
            s.PCSrcE     = ($urandom_range(0, 4) == 0);
            applyStimulus(s);
            checkOutput();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
